// File: rtl/lpif_pkg.sv
// rtl/lpif_pkg.sv - LPIF link-state codes and sizing helpers shared by the tx buffer.
package lpif_pkg;

  typedef enum logic [3:0] {
    LS_RESET     = 4'h0,
    LS_ACTIVE    = 4'h1,
    LS_LINKRESET = 4'h9,
    LS_LINKERROR = 4'hA,
    LS_RETRAIN   = 4'hB,
    LS_DISABLED  = 4'hC
  } lpif_state_e;

  // Each stored entry is the beat data plus six per-byte side fields.
  localparam int LPIF_SIDE_FIELDS = 6;

  function automatic int lpif_nb(input int bus_width);
    return bus_width / 8;
  endfunction

  function automatic int lpif_entry_width(input int bus_width);
    return bus_width + LPIF_SIDE_FIELDS * (bus_width / 8);
  endfunction

endpackage

// File: rtl/lpif_fifo_ram.sv
// rtl/lpif_fifo_ram.sv - Entry storage: one synchronous write port, one asynchronous read port.
module lpif_fifo_ram #(
  parameter int WIDTH = 448,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are qualified by the pointers, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lpif_tx_fifo.sv
// rtl/lpif_tx_fifo.sv - LPIF transmit elastic buffer with link-state gated dequeue,
// flush on link-down and a sticky TLP framing checker.
module lpif_tx_fifo
  import lpif_pkg::*;
#(
  parameter int LPIF_BUS_WIDTH = 256,
  parameter int DEPTH = 8,
  localparam int NB = LPIF_BUS_WIDTH / 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                      lclk,
  input  logic                      reset,
  input  logic                      lp_irdy,
  input  logic [LPIF_BUS_WIDTH-1:0] lp_data,
  input  logic [NB-1:0]             lp_valid,
  input  logic [NB-1:0]             lp_tlp_start,
  input  logic [NB-1:0]             lp_tlp_end,
  input  logic [NB-1:0]             lp_dllp_start,
  input  logic [NB-1:0]             lp_dllp_end,
  input  logic [NB-1:0]             lp_tlpedb,
  output logic                      pl_trdy,
  input  logic                      pl_linkup,
  input  logic [3:0]                pl_state_sts,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [LPIF_BUS_WIDTH-1:0] tx_data,
  output logic [NB-1:0]             tx_valid_b,
  output logic [NB-1:0]             tx_tlp_start,
  output logic [NB-1:0]             tx_tlp_end,
  output logic [NB-1:0]             tx_dllp_start,
  output logic [NB-1:0]             tx_dllp_end,
  output logic [NB-1:0]             tx_tlpedb,
  output logic [CW-1:0]             occupancy,
  output logic                      frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = lpif_entry_width(LPIF_BUS_WIDTH);

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] occ_n;
  logic          flush_q;
  logic          in_tlp;
  logic          wr_en, rd_en, empty, full_n, trdy_n;
  logic          tlp_scan, beat_err;
  logic [EW-1:0] wr_entry, rd_entry;

  assign empty    = (wr_ptr == rd_ptr);
  assign wr_en    = lp_irdy && pl_trdy && !flush_q;
  assign tx_valid = !empty && (pl_state_sts == LS_ACTIVE) && !flush_q;
  assign rd_en    = tx_valid && tx_ready;

  assign wr_entry = {lp_tlpedb, lp_dllp_end, lp_dllp_start,
                     lp_tlp_end, lp_tlp_start, lp_valid, lp_data};
  assign {tx_tlpedb, tx_dllp_end, tx_dllp_start,
          tx_tlp_end, tx_tlp_start, tx_valid_b, tx_data} = rd_entry;

  lpif_fifo_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (lclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_entry)
  );

  // pl_trdy is registered from the post-edge fullness so it never sees tx_ready combinationally.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    occ_n    = occupancy;
    if (flush_q) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      occ_n    = '0;
    end else begin
      wr_ptr_n = wr_ptr + PW'(wr_en);
      rd_ptr_n = rd_ptr + PW'(rd_en);
      case ({wr_en, rd_en})
        2'b10:   occ_n = occupancy + CW'(1);
        2'b01:   occ_n = occupancy - CW'(1);
        default: occ_n = occupancy;
      endcase
    end
    full_n = (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) && (wr_ptr_n[AW] != rd_ptr_n[AW]);
    trdy_n = !full_n && pl_linkup;
  end

  // Lanes are scanned low to high; a start and a later end in one beat is a complete TLP.
  always_comb begin
    tlp_scan = in_tlp;
    beat_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (lp_tlp_start[i]) begin
        if (tlp_scan) beat_err = 1'b1;
        tlp_scan = 1'b1;
      end
      if (lp_tlp_end[i]) begin
        if (!tlp_scan) beat_err = 1'b1;
        tlp_scan = 1'b0;
      end
    end
  end

  always_ff @(posedge lclk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      flush_q   <= 1'b1;
      pl_trdy   <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      occupancy <= occ_n;
      flush_q   <= !pl_linkup;
      pl_trdy   <= trdy_n;
    end
  end

  always_ff @(posedge lclk or negedge reset) begin
    if (!reset) begin
      in_tlp    <= 1'b0;
      frame_err <= 1'b0;
    end else if (flush_q) begin
      in_tlp    <= 1'b0;
      frame_err <= 1'b0;
    end else if (wr_en) begin
      in_tlp <= tlp_scan;
      if (beat_err) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lpif_tx_fifo.sv
// tb/tb_lpif_tx_fifo.sv - Randomized self-checking bench for lpif_tx_fifo against a queue model.
module tb_lpif_tx_fifo;

  localparam int W     = 256;
  localparam int NB    = W / 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [NB-1:0] eb;
    logic [NB-1:0] de;
    logic [NB-1:0] ds;
    logic [NB-1:0] te;
    logic [NB-1:0] ts;
    logic [NB-1:0] v;
    logic [W-1:0]  d;
  } beat_t;

  logic          lclk = 1'b0;
  logic          reset;
  logic          lp_irdy;
  logic [W-1:0]  lp_data;
  logic [NB-1:0] lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end, lp_tlpedb;
  logic          pl_trdy;
  logic          pl_linkup;
  logic [3:0]    pl_state_sts;
  logic          tx_valid;
  logic          tx_ready;
  logic [W-1:0]  tx_data;
  logic [NB-1:0] tx_valid_b, tx_tlp_start, tx_tlp_end, tx_dllp_start, tx_dllp_end, tx_tlpedb;
  logic [CW-1:0] occupancy;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  beat_t q[$];
  bit    m_flush, m_trdy, m_err, m_in_tlp;

  lpif_tx_fifo #(.LPIF_BUS_WIDTH(W), .DEPTH(DEPTH)) dut (
    .lclk          (lclk),
    .reset         (reset),
    .lp_irdy       (lp_irdy),
    .lp_data       (lp_data),
    .lp_valid      (lp_valid),
    .lp_tlp_start  (lp_tlp_start),
    .lp_tlp_end    (lp_tlp_end),
    .lp_dllp_start (lp_dllp_start),
    .lp_dllp_end   (lp_dllp_end),
    .lp_tlpedb     (lp_tlpedb),
    .pl_trdy       (pl_trdy),
    .pl_linkup     (pl_linkup),
    .pl_state_sts  (pl_state_sts),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_valid_b    (tx_valid_b),
    .tx_tlp_start  (tx_tlp_start),
    .tx_tlp_end    (tx_tlp_end),
    .tx_dllp_start (tx_dllp_start),
    .tx_dllp_end   (tx_dllp_end),
    .tx_tlpedb     (tx_tlpedb),
    .occupancy     (occupancy),
    .frame_err     (frame_err)
  );

  always #5 lclk = ~lclk;

  function automatic beat_t cur_beat();
    beat_t b;
    b = '{eb: lp_tlpedb, de: lp_dllp_end, ds: lp_dllp_start, te: lp_tlp_end,
          ts: lp_tlp_start, v: lp_valid, d: lp_data};
    return b;
  endfunction

  // A TLP opens on a start and closes on an end; two opens or an orphan close is malformed.
  function automatic bit frame_bad(input beat_t b, inout bit open);
    bit bad = 0;
    for (int i = 0; i < NB; i++) begin
      if (b.ts[i]) begin
        if (open) bad = 1;
        open = 1;
      end
      if (b.te[i]) begin
        if (!open) bad = 1;
        open = 0;
      end
    end
    return bad;
  endfunction

  task automatic model_reset();
    q.delete();
    m_flush = 1; m_trdy = 0; m_err = 0; m_in_tlp = 0;
  endtask

  task automatic rand_beat(input bit clean);
    for (int i = 0; i < W / 32; i++) lp_data[i*32 +: 32] = $urandom();
    lp_valid      = $urandom();
    lp_dllp_start = $urandom();
    lp_dllp_end   = $urandom();
    lp_tlpedb     = $urandom();
    lp_tlp_start  = '0;
    lp_tlp_end    = '0;
    if (!clean) begin
      if ($urandom_range(0, 3) == 0) lp_tlp_start[$urandom_range(0, NB - 1)] = 1'b1;
      if ($urandom_range(0, 3) == 0) lp_tlp_end[$urandom_range(0, NB - 1)] = 1'b1;
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance both across the edge.
  task automatic step();
    bit    exp_v, push, pop, bad, open;
    beat_t b, got;
    #1;
    exp_v = (q.size() > 0) && (pl_state_sts == 4'h1) && !m_flush;
    checks++;
    if (tx_valid !== exp_v) begin
      errors++; $display("FAIL tx_valid got %0b expected %0b at %0t", tx_valid, exp_v, $time);
    end
    checks++;
    if (pl_trdy !== m_trdy) begin
      errors++; $display("FAIL pl_trdy got %0b expected %0b at %0t", pl_trdy, m_trdy, $time);
    end
    checks++;
    if (int'(occupancy) !== q.size()) begin
      errors++; $display("FAIL occupancy got %0d expected %0d at %0t", occupancy, q.size(), $time);
    end
    checks++;
    if (frame_err !== m_err) begin
      errors++; $display("FAIL frame_err got %0b expected %0b at %0t", frame_err, m_err, $time);
    end
    if (exp_v) begin
      got = '{eb: tx_tlpedb, de: tx_dllp_end, ds: tx_dllp_start, te: tx_tlp_end,
              ts: tx_tlp_start, v: tx_valid_b, d: tx_data};
      checks++;
      if (got !== q[0]) begin
        errors++; $display("FAIL head_entry got %h expected %h at %0t", got.d, q[0].d, $time);
      end
    end
    push = lp_irdy && m_trdy;
    pop  = exp_v && tx_ready;
    b    = cur_beat();
    @(posedge lclk);
    if (m_flush) begin
      q.delete(); m_err = 0; m_in_tlp = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(b);
        open = m_in_tlp;
        bad  = frame_bad(b, open);
        m_in_tlp = open;
        if (bad) m_err = 1;
      end
    end
    m_trdy  = pl_linkup && (q.size() < DEPTH);
    m_flush = !pl_linkup;
    @(negedge lclk);
  endtask

  task automatic idle();
    lp_irdy = 0; tx_ready = 0;
  endtask

  task automatic test_reset();
    reset = 0; pl_linkup = 1; pl_state_sts = 4'h1; idle(); rand_beat(1);
    model_reset();
    repeat (2) @(negedge lclk);
    checks++;
    if (pl_trdy !== 1'b0 || tx_valid !== 1'b0 || occupancy !== '0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_state got trdy=%0b valid=%0b occ=%0d err=%0b expected all 0",
                         pl_trdy, tx_valid, occupancy, frame_err);
    end
    reset = 1;
    step();
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 10; i++) begin
      rand_beat(1); lp_irdy = 1; tx_ready = 0; step();
    end
    idle(); step();
    checks++;
    if (occupancy !== CW'(DEPTH) || pl_trdy !== 1'b0) begin
      errors++; $display("FAIL fill got occ=%0d trdy=%0b expected occ=%0d trdy=0", occupancy, pl_trdy, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tx_ready = 1; step();
    end
    idle(); step();
    checks++;
    if (occupancy !== '0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL drain got occ=%0d valid=%0b expected 0 0", occupancy, tx_valid);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 20; i++) begin
      rand_beat(1); lp_irdy = 1; tx_ready = 1; step();
      if (i > 0) begin
        checks++;
        if (occupancy !== CW'(1)) begin
          errors++; $display("FAIL stream_occ got %0d expected 1", occupancy);
        end
      end
    end
    idle(); tx_ready = 1; step(); idle();
  endtask

  task automatic test_state_gate();
    for (int i = 0; i < 3; i++) begin
      rand_beat(1); lp_irdy = 1; step();
    end
    idle(); pl_state_sts = 4'h0; tx_ready = 1;
    step(); step();
    checks++;
    if (tx_valid !== 1'b0 || occupancy !== CW'(3)) begin
      errors++; $display("FAIL state_gate got valid=%0b occ=%0d expected 0 3", tx_valid, occupancy);
    end
    pl_state_sts = 4'h1;
    repeat (4) step();
    checks++;
    if (occupancy !== '0) begin
      errors++; $display("FAIL state_drain got occ=%0d expected 0", occupancy);
    end
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      rand_beat(1); lp_irdy = 1; step();
    end
    rand_beat(1); lp_irdy = 1; pl_linkup = 0;
    step();
    idle(); step();
    checks++;
    if (occupancy !== '0 || pl_trdy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL flush got occ=%0d trdy=%0b valid=%0b expected 0 0 0",
                         occupancy, pl_trdy, tx_valid);
    end
    pl_linkup = 1; step();
    for (int i = 0; i < 3; i++) begin
      rand_beat(1); lp_irdy = 1; step();
    end
    idle(); step();
    checks++;
    if (occupancy !== CW'(3)) begin
      errors++; $display("FAIL relink got occ=%0d expected 3", occupancy);
    end
    tx_ready = 1; repeat (4) step(); idle();
  endtask

  task automatic do_flush();
    idle(); pl_linkup = 0; step(); step(); pl_linkup = 1; step();
  endtask

  task automatic test_framing();
    tx_ready = 1;
    rand_beat(1); lp_tlp_start[0] = 1; lp_irdy = 1; step();
    rand_beat(1); lp_tlp_start[4] = 1; step();
    idle(); tx_ready = 1; step(); step();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL frame_double_start got %0b expected 1", frame_err);
    end
    do_flush();
    tx_ready = 1;
    rand_beat(1); lp_tlp_start[0] = 1; lp_tlp_end[7] = 1; lp_irdy = 1; step();
    rand_beat(1); lp_tlp_start[2] = 1; step();
    rand_beat(1); lp_tlp_end[30] = 1; step();
    idle(); tx_ready = 1; step();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL frame_legal got %0b expected 0", frame_err);
    end
    rand_beat(1); lp_tlp_end[1] = 1; lp_irdy = 1; step();
    idle(); tx_ready = 1; step();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL frame_orphan_end got %0b expected 1", frame_err);
    end
    do_flush();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      rand_beat(1); lp_irdy = 1; tx_ready = 0; step();
    end
    idle();
    reset = 0;
    #1;
    checks++;
    if (occupancy !== '0 || tx_valid !== 1'b0 || pl_trdy !== 1'b0) begin
      errors++; $display("FAIL reset_mid got occ=%0d valid=%0b trdy=%0b expected 0 0 0",
                         occupancy, tx_valid, pl_trdy);
    end
    model_reset();
    @(negedge lclk);
    reset = 1;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_beat(0);
      lp_irdy      = ($urandom_range(0, 3) != 0);
      tx_ready     = ($urandom_range(0, 2) != 0);
      pl_state_sts = ($urandom_range(0, 7) == 0) ? 4'hB : 4'h1;
      pl_linkup    = ($urandom_range(0, 40) != 0);
      step();
    end
    pl_linkup = 1; pl_state_sts = 4'h1; idle(); step();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_state_gate();
    test_flush();
    test_framing();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpif_tx_fifo.md
# lpif_tx_fifo

Parametrised transmit-side elastic buffer between the link layer and the physical layer on the LPIF boundary. Accepts beats of data with byte-valids and TLP/DLLP framing markers from the link layer under the `lp_irdy`/`pl_trdy` handshake and presents them to the PHY transmit path under a valid/ready handshake. Dequeue is gated by the reported link state and the whole buffer is flushed on link-down. A sticky framing checker flags malformed TLP start/end sequences.

## Interface

Parameters:
- `LPIF_BUS_WIDTH`, 256: data width in bits; multiple of 8, ≥ 32.
- `DEPTH`, 8: number of beat entries; power of two, ≥ 2.
- Derived: `NB = LPIF_BUS_WIDTH/8` (byte lanes); `CW = $clog2(DEPTH+1)`.

Ports:
- `lclk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `lp_irdy` in 1: link layer has a beat.
- `lp_data` in `LPIF_BUS_WIDTH`: beat data.
- `lp_valid`, `lp_tlp_start`, `lp_tlp_end`, `lp_dllp_start`, `lp_dllp_end`, `lp_tlpedb` in `NB` each: per-byte valid and markers.
- `pl_trdy` out 1: buffer can accept a beat.
- `pl_linkup` in 1: link up; low means flush.
- `pl_state_sts` in 4: link state; dequeue only in ACTIVE (4'h1).
- `tx_valid` out 1: head entry presented.
- `tx_ready` in 1: PHY consumes head.
- `tx_data` out `LPIF_BUS_WIDTH`; `tx_valid_b`, `tx_tlp_start`, `tx_tlp_end`, `tx_dllp_start`, `tx_dllp_end`, `tx_tlpedb` out `NB` each: head entry fields.
- `occupancy` out `CW`: stored entries.
- `frame_err` out 1: sticky framing error.

## Operation

- Write: `lp_irdy && pl_trdy` stores one entry (data + all six `NB`-bit fields) at wr_ptr.
- `pl_trdy = !full && pl_linkup && !flush_q`; registered, never depends combinationally on `tx_ready`.
- Read: `tx_valid = !empty && pl_state_sts == ACTIVE && !flush_q`. `tx_valid && tx_ready` pops. Outputs are first-word-fall-through from storage at rd_ptr.
- Pointers are `$clog2(DEPTH)+1` bits with wrap bit; full = addresses equal, wrap bits differ; empty = pointers equal.
- `occupancy` +1 on write only, −1 on read only, unchanged on both.
- Flush: `flush_q` registers `!pl_linkup`. While `flush_q`: pointers, occupancy, in_tlp and `frame_err` clear; no writes, no reads.
- Framing checker (accepted beats only), lanes scanned 0→NB−1 with in_tlp state: start while in_tlp → error; end while !in_tlp → error; start then end in one beat legal. in_tlp persists across beats. `frame_err` sets and holds until reset or flush.
- `pl_state_sts` leaving ACTIVE stalls dequeue only; writes continue until full.
- Reset values: `pl_trdy` 0, `tx_valid` 0, `occupancy` 0, `frame_err` 0, `flush_q` 1 (first cycle after reset release deasserts it if `pl_linkup`); `tx_*` data fields don't-care while `tx_valid` low.

## Timing

- Write-to-`tx_valid` latency: 1 cycle (entry written at edge N visible after edge N).
- `pl_trdy` reflects full status from the previous edge: after write making occupancy `DEPTH`, `pl_trdy` low next cycle; pop when full raises `pl_trdy` next cycle.
- Simultaneous push/pop at occupancy `DEPTH−1` or 1: occupancy unchanged, no full/empty glitch.
- `pl_linkup` falling at edge N: `flush_q` high after N, state cleared at N+1; beat offered in cycle N with `pl_trdy` high is accepted then discarded.
- Asynchronous reset mid-operation: all state to reset values immediately; contents discarded.

## Structure

- Package `lpif_pkg`: link-state codes (RESET 4'h0, ACTIVE 4'h1, …), `lpif_beat_t` struct parametrised by field widths is avoided; instead package holds localparam helpers for `NB` and entry width `LPIF_BUS_WIDTH + 6*NB`.
- Sub-module `lpif_fifo_ram`: `DEPTH × entry-width` register array, one write port, one asynchronous read port; no reset on storage.
- Top holds pointers, handshake, flush, occupancy and framing checker.

## Test plan

- Fill/drain: `DEPTH`=8, ACTIVE, `tx_ready`=0, 10 beats offered → 8 accepted, `pl_trdy` low, `occupancy`=8; `tx_ready`=1 → 8 beats out in order, `occupancy`=0.
- Streaming: both sides always ready → one beat/cycle, 1-cycle latency, `occupancy` steady at 1.
- State gate: 3 beats stored, `pl_state_sts`=4'h0 → `tx_valid`=0; return to 4'h1 → 3 beats drain.
- Flush: 5 stored, `pl_linkup` 1→0 → 2 cycles later `occupancy`=0, `pl_trdy`=0, `tx_valid`=0; relink → accepts new beats.
- Framing: lane 0 start, next beat lane 4 start → `frame_err`=1 held; start+end same beat from idle → no error.
- Reset mid-stream: assert `reset`=0 with 4 stored → `occupancy`=0, `tx_valid`=0 immediately.
